// File: rtl/rv32im_pc.sv
// Fetch-stage program counter: registered PC plus combinational PC+4 and misalignment status.
// Defining RV32IM_PC_STALL_EN adds the stall_i input and the registered stalled_o output.
module rv32im_pc #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset_n,
`ifdef RV32IM_PC_STALL_EN
    input  logic            stall_i,
`endif
    input  logic [XLEN-1:0] pc_next_i,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4_o,
`ifdef RV32IM_PC_STALL_EN
    output logic            stalled_o,
`endif
    output logic            misaligned_o
);

    logic [XLEN-1:0] pc_d, pc_q;

`ifdef RV32IM_PC_STALL_EN
    logic stalled_d, stalled_q;

    always_comb begin
        pc_d      = pc_next_i;
        stalled_d = 1'b0;
        if (stall_i) begin
            pc_d      = pc_q;
            stalled_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stalled_q <= 1'b0;
        end else begin
            stalled_q <= stalled_d;
        end
    end

    assign stalled_o = stalled_q;
`else
    always_comb begin
        pc_d = pc_next_i;
    end
`endif

    // Reset wins over load and stall; the pc_next_i value at a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc           = pc_q;
    assign pc_plus4_o   = pc_q + XLEN'(4);
    assign misaligned_o = |pc_q[1:0];

endmodule

// File: tb/tb_rv32im_pc.sv
// Directed bench for rv32im_pc: a scoreboard queue holds the expected PC state for every edge.
// The stall checks are built only when RV32IM_PC_STALL_EN is defined.
module tb_rv32im_pc;

`ifdef RV32IM_PC_STALL_EN
    localparam bit Stall = 1'b1;
`else
    localparam bit Stall = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic        stalled;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        stall_i = 1'b0;
    logic [31:0] pc_next_i = '0;
    logic [31:0] pc;
    logic [31:0] pc_plus4_o;
    logic        misaligned_o;
    logic        stalled_o;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [31:0] model_pc = '0;

    always #5 clk = ~clk;

    rv32im_pc #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
`ifdef RV32IM_PC_STALL_EN
        .stall_i      (stall_i),
        .stalled_o    (stalled_o),
`endif
        .pc_next_i    (pc_next_i),
        .pc           (pc),
        .pc_plus4_o   (pc_plus4_o),
        .misaligned_o (misaligned_o)
    );

`ifndef RV32IM_PC_STALL_EN
    assign stalled_o = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one edge's inputs, predict the result, then compare once the edge has passed.
    task automatic step(input string tag, input logic [31:0] nxt, input logic rst,
                        input logic stl);
        exp_t e;
        pc_next_i = nxt;
        reset_n   = rst;
        stall_i   = stl;
        if (!rst) begin
            model_pc = 32'h0000_0000;
        end else if (!(Stall && stl)) begin
            model_pc = nxt;
        end
        e.pc      = model_pc;
        e.stalled = rst && stl && Stall;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".pc"}, pc, e.pc);
        check({tag, ".plus4"}, pc_plus4_o, e.pc + 32'd4);
        check({tag, ".mis"}, {31'd0, misaligned_o}, {31'd0, (e.pc[1:0] != 2'b00)});
        if (Stall) begin
            check({tag, ".stalled"}, {31'd0, stalled_o}, {31'd0, e.stalled});
        end
    endtask

    initial begin
        #1;
        step("reset", 32'h0000_1234, 1'b0, 1'b0);

        for (int i = 0; i < 100; i++) begin
            step("seq", i, 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            step("hold99", 32'd99, 1'b1, 1'b0);
        end

        step("mis1", 32'd1, 1'b1, 1'b0);
        step("mis2", 32'd2, 1'b1, 1'b0);
        step("mis3", 32'd3, 1'b1, 1'b0);
        step("mis4", 32'd4, 1'b1, 1'b0);

        step("wrap", 32'hFFFF_FFFC, 1'b1, 1'b0);
        step("high", 32'hDEAD_BEEF, 1'b1, 1'b0);

        step("pre_rst", 32'h0000_0040, 1'b1, 1'b0);
        step("mid_rst", 32'h0000_0044, 1'b0, 1'b0);
        step("post_rst", 32'h0000_0044, 1'b1, 1'b0);

        if (Stall) begin
            step("st_load", 32'd8, 1'b1, 1'b0);
            step("st_hold1", 32'd12, 1'b1, 1'b1);
            step("st_hold2", 32'd12, 1'b1, 1'b1);
            step("st_rel", 32'd12, 1'b1, 1'b0);
            step("st_pre", 32'd16, 1'b1, 1'b1);
            step("st_rst", 32'd20, 1'b0, 1'b1);
            step("st_after", 32'd20, 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
